vdp_vram_arb: RTL and testbench
===============================

VDP_VRAM_ARB -- requirements
Module: vdp_vram_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, VRAM address width in bits.
REQ-002 SHALL have port pxclk  input  1  pixel clock (25 MHz); all logic on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports dma_addr  input  ADDR_W  renderer fetch address, and dma_rd_tick  input  1  renderer read request.
REQ-005 SHALL have port vram_dout  output  8  renderer read data.
REQ-006 SHALL have ports cpu_addr_tick  input  1  load address pulse; cpu_addr_in  input  ADDR_W  address to load; cpu_addr_rd  input  1  prefetch-on-load flag.
REQ-007 SHALL have ports cpu_wr_tick  input  1  CPU data write pulse; cpu_wdata  input  8  CPU write data; cpu_rd_tick  input  1  CPU data read pulse; cpu_rdata  output  8  read-ahead buffer.
REQ-008 SHALL have ports ram_addr  output  ADDR_W; ram_we  output  1; ram_wdata  output  8; ram_rdata  input  8; RAM is synchronous with 1-clock read latency.
REQ-009 SHALL have ports cpu_wait  output  1  request pending, and cpu_overrun  output  1  sticky dropped-request flag.

Function
REQ-010 SHALL give the renderer absolute priority: in any cycle with dma_rd_tick=1, ram_addr=dma_addr and ram_we=0, combinationally.
REQ-011 SHALL present ram_rdata on vram_dout in the cycle immediately after a dma_rd_tick cycle, with zero added latency.
REQ-012 SHALL hold an internal CPU address pointer cpu_ptr (ADDR_W bits) that wraps from 2^ADDR_W-1 to 0 on increment.
REQ-013 SHALL run a CPU-side FSM with states IDLE, WR_PEND, RD_PEND, RD_CAP.
REQ-014 SHALL, on cpu_addr_tick in IDLE, load cpu_ptr=cpu_addr_in, and go to RD_PEND if cpu_addr_rd=1, else stay in IDLE.
REQ-015 SHALL, on cpu_wr_tick in IDLE, latch cpu_wdata and go to WR_PEND.
REQ-016 SHALL, on cpu_rd_tick in IDLE, go to RD_PEND; cpu_rdata keeps its old value, which is the byte returned to the CPU.
REQ-017 SHALL, in WR_PEND during a cycle with dma_rd_tick=0: drive ram_addr=cpu_ptr, ram_we=1, ram_wdata=latched data; increment cpu_ptr; go to IDLE.
REQ-018 SHALL, in RD_PEND during a cycle with dma_rd_tick=0: drive ram_addr=cpu_ptr, ram_we=0; go to RD_CAP.
REQ-019 SHALL, in RD_CAP: load cpu_rdata=ram_rdata; increment cpu_ptr; go to IDLE.
REQ-020 SHALL stall WR_PEND and RD_PEND while dma_rd_tick=1, with no limit on stall length.
REQ-021 SHALL give simultaneous CPU pulses in IDLE this priority: cpu_addr_tick > cpu_wr_tick > cpu_rd_tick; the lower-priority pulses SHALL be dropped and SHALL set cpu_overrun.
REQ-022 SHALL drop any CPU pulse arriving outside IDLE, set cpu_overrun, and leave the pending operation unaffected.
REQ-023 SHALL clear cpu_overrun only by reset.
REQ-024 SHALL drive ram_we=0 and ram_addr=cpu_ptr in cycles with no access.

Reset
REQ-025 SHALL, on reset, set: FSM=IDLE, cpu_ptr=0, cpu_rdata=0, latched write data=0, cpu_overrun=0, cpu_wait=0, ram_we=0.
REQ-026 SHALL abandon any pending CPU operation on reset, with no RAM write issued in the reset cycle.
REQ-027 SHALL NOT gate vram_dout by reset; it always follows REQ-011.

Configuration
REQ-028 SHALL, with macro VDP_ARB_WAIT_EN defined, drive cpu_wait=1 whenever the FSM is not in IDLE.
REQ-029 SHALL, without VDP_ARB_WAIT_EN, tie cpu_wait to 0; all other behaviour is identical.

Verification
REQ-030 SHALL cover write: addr_tick 0x1234 (rd=0), wr_tick 0xA5 with no DMA -> ram_we=1 at addr 0x1234, data 0xA5 one cycle later; cpu_ptr=0x1235.
REQ-031 SHALL cover prefetch: RAM[0x0100]=0x5A, addr_tick 0x0100 (rd=1) -> cpu_rdata=0x5A within 3 clocks; cpu_ptr=0x0101.
REQ-032 SHALL cover stall: dma_rd_tick held high 5 cycles with a write pending -> no ram_we during those cycles; write issued in the first cycle after dma_rd_tick falls; vram_dout correct on every DMA.
REQ-033 SHALL cover wrap: addr_tick 0x3FFF then wr_tick -> write at 0x3FFF; cpu_ptr=0x0000.
REQ-034 SHALL cover overrun: wr_tick followed by a second wr_tick while dma_rd_tick=1 -> second pulse dropped; cpu_overrun=1 until reset.
REQ-035 SHALL cover reset mid-operation: reset asserted in WR_PEND -> no RAM write occurs; all outputs at REQ-025 values; cpu_wait=0 in both VDP_ARB_WAIT_EN builds.

Source files
------------

// File: rtl/vdp_vram_arb.sv
// VRAM arbiter: renderer DMA reads take absolute priority, CPU port sequences writes/reads through a pointer FSM.
// Optional macro VDP_ARB_WAIT_EN drives cpu_wait while a CPU access is pending; otherwise cpu_wait is tied low.
module vdp_vram_arb #(
  parameter int ADDR_W = 14
) (
  input  logic              pxclk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic              dma_rd_tick,
  output logic [7:0]        vram_dout,
  input  logic              cpu_addr_tick,
  input  logic [ADDR_W-1:0] cpu_addr_in,
  input  logic              cpu_addr_rd,
  input  logic              cpu_wr_tick,
  input  logic [7:0]        cpu_wdata,
  input  logic              cpu_rd_tick,
  output logic [7:0]        cpu_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic              cpu_wait,
  output logic              cpu_overrun
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_PEND = 2'd1,
    ST_RD_PEND = 2'd2,
    ST_RD_CAP  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_cpu_ptr;
  logic [ADDR_W-1:0] w_cpu_ptr_nxt;
  logic [7:0]        r_wdata;
  logic [7:0]        w_wdata_nxt;
  logic [7:0]        r_rdata;
  logic [7:0]        w_rdata_nxt;
  logic              r_overrun;
  logic              w_overrun_nxt;
  logic              r_dma_d;
  logic [7:0]        r_vram_hold;
  logic              w_any_pulse;
  logic              w_multi_pulse;
  logic [ADDR_W-1:0] w_ram_addr;
  logic              w_ram_we;

  assign w_any_pulse   = cpu_addr_tick | cpu_wr_tick | cpu_rd_tick;
  assign w_multi_pulse = (cpu_addr_tick & (cpu_wr_tick | cpu_rd_tick)) | (cpu_wr_tick & cpu_rd_tick);

  // CPU FSM next-state, pointer/data updates and RAM port mux
  always_comb begin
    w_state_nxt   = r_state;
    w_cpu_ptr_nxt = r_cpu_ptr;
    w_wdata_nxt   = r_wdata;
    w_rdata_nxt   = r_rdata;
    w_overrun_nxt = r_overrun;
    w_ram_addr    = r_cpu_ptr;
    w_ram_we      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (cpu_addr_tick) begin
          w_cpu_ptr_nxt = cpu_addr_in;
          w_state_nxt   = cpu_addr_rd ? ST_RD_PEND : ST_IDLE;
        end else if (cpu_wr_tick) begin
          w_wdata_nxt = cpu_wdata;
          w_state_nxt = ST_WR_PEND;
        end else if (cpu_rd_tick) begin
          w_state_nxt = ST_RD_PEND;
        end else begin
          w_state_nxt = ST_IDLE;
        end
        if (w_multi_pulse) begin
          w_overrun_nxt = 1'b1;
        end else begin
          w_overrun_nxt = r_overrun;
        end
      end
      ST_WR_PEND: begin
        if (!dma_rd_tick) begin
          w_ram_we      = 1'b1;
          w_cpu_ptr_nxt = r_cpu_ptr + PTR_ONE;
          w_state_nxt   = ST_IDLE;
        end else begin
          w_state_nxt = ST_WR_PEND;
        end
        if (w_any_pulse) begin
          w_overrun_nxt = 1'b1;
        end else begin
          w_overrun_nxt = r_overrun;
        end
      end
      ST_RD_PEND: begin
        if (!dma_rd_tick) begin
          w_state_nxt = ST_RD_CAP;
        end else begin
          w_state_nxt = ST_RD_PEND;
        end
        if (w_any_pulse) begin
          w_overrun_nxt = 1'b1;
        end else begin
          w_overrun_nxt = r_overrun;
        end
      end
      ST_RD_CAP: begin
        // ram_rdata here answers the address presented during RD_PEND
        w_rdata_nxt   = ram_rdata;
        w_cpu_ptr_nxt = r_cpu_ptr + PTR_ONE;
        w_state_nxt   = ST_IDLE;
        if (w_any_pulse) begin
          w_overrun_nxt = 1'b1;
        end else begin
          w_overrun_nxt = r_overrun;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (dma_rd_tick) begin
      w_ram_addr = dma_addr;
      w_ram_we   = 1'b0;
    end else begin
      w_ram_addr = w_ram_addr;
    end

    // a write still pending when reset arrives must not reach the RAM
    if (reset) begin
      w_ram_we = 1'b0;
    end else begin
      w_ram_we = w_ram_we;
    end
  end

  // CPU-side state registers
  always_ff @(posedge pxclk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cpu_ptr <= '0;
      r_wdata   <= 8'h00;
      r_rdata   <= 8'h00;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cpu_ptr <= w_cpu_ptr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_rdata   <= w_rdata_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

  // Renderer return path: deliberately independent of reset
  always_ff @(posedge pxclk) begin
    r_dma_d <= dma_rd_tick;
    if (r_dma_d) begin
      r_vram_hold <= ram_rdata;
    end else begin
      r_vram_hold <= r_vram_hold;
    end
  end

  assign vram_dout   = r_dma_d ? ram_rdata : r_vram_hold;
  assign ram_addr    = w_ram_addr;
  assign ram_we      = w_ram_we;
  assign ram_wdata   = r_wdata;
  assign cpu_rdata   = r_rdata;
  assign cpu_overrun = r_overrun;

`ifdef VDP_ARB_WAIT_EN
  logic r_wait;

  // Busy flag tracks the registered FSM state
  always_ff @(posedge pxclk) begin
    if (reset) begin
      r_wait <= 1'b0;
    end else begin
      r_wait <= (w_state_nxt != ST_IDLE);
    end
  end

  assign cpu_wait = r_wait;
`else
  assign cpu_wait = 1'b0;
`endif

endmodule

// File: tb/tb_vdp_vram_arb.sv
// Self-checking bench for vdp_vram_arb: directed scenarios plus a randomized transaction run
// checked against a transaction-level memory/pointer model.
module tb_vdp_vram_arb;

  localparam int AW = 14;
  localparam int DEPTH = 1 << AW;
`ifdef VDP_ARB_WAIT_EN
  localparam logic EXP_WAIT_BUSY = 1'b1;
`else
  localparam logic EXP_WAIT_BUSY = 1'b0;
`endif

  logic          pxclk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] dma_addr = '0;
  logic          dma_rd_tick = 1'b0;
  logic [7:0]    vram_dout;
  logic          cpu_addr_tick = 1'b0;
  logic [AW-1:0] cpu_addr_in = '0;
  logic          cpu_addr_rd = 1'b0;
  logic          cpu_wr_tick = 1'b0;
  logic [7:0]    cpu_wdata = 8'h00;
  logic          cpu_rd_tick = 1'b0;
  logic [7:0]    cpu_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram_rdata = 8'h00;
  logic          cpu_wait;
  logic          cpu_overrun;

  logic [7:0] ram_mem   [0:DEPTH-1];
  logic [7:0] model_mem [0:DEPTH-1];

  int n_cmp = 0;
  int n_err = 0;

  vdp_vram_arb #(.ADDR_W(AW)) dut (
    .pxclk(pxclk), .reset(reset),
    .dma_addr(dma_addr), .dma_rd_tick(dma_rd_tick), .vram_dout(vram_dout),
    .cpu_addr_tick(cpu_addr_tick), .cpu_addr_in(cpu_addr_in), .cpu_addr_rd(cpu_addr_rd),
    .cpu_wr_tick(cpu_wr_tick), .cpu_wdata(cpu_wdata), .cpu_rd_tick(cpu_rd_tick),
    .cpu_rdata(cpu_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .cpu_wait(cpu_wait), .cpu_overrun(cpu_overrun)
  );

  always #20 pxclk = ~pxclk;

  // Synchronous RAM, one-clock read latency, read-before-write
  always @(posedge pxclk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  task automatic cyc();
    @(posedge pxclk);
    #1;
  endtask

  task automatic clear_cpu();
    cpu_addr_tick = 1'b0;
    cpu_wr_tick   = 1'b0;
    cpu_rd_tick   = 1'b0;
  endtask

  task automatic do_reset();
    clear_cpu();
    dma_rd_tick = 1'b0;
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic load_addr(input logic [AW-1:0] a, input logic rd);
    cpu_addr_tick = 1'b1; cpu_addr_in = a; cpu_addr_rd = rd;
    cyc();
    clear_cpu();
  endtask

  task automatic write_pulse(input logic [7:0] d);
    cpu_wr_tick = 1'b1; cpu_wdata = d;
    cyc();
    clear_cpu();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge pxclk);
    n_cmp++; if (cpu_rdata !== 8'h00) begin n_err++; $display("FAIL reset_rdata got %h exp 00", cpu_rdata); end
    n_cmp++; if (cpu_overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun got %b exp 0", cpu_overrun); end
    n_cmp++; if (cpu_wait !== 1'b0) begin n_err++; $display("FAIL reset_wait got %b exp 0", cpu_wait); end
    n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL reset_we got %b exp 0", ram_we); end
    n_cmp++; if (ram_addr !== 14'h0000) begin n_err++; $display("FAIL reset_addr got %h exp 0000", ram_addr); end
  endtask

  task automatic test_write();
    do_reset();
    load_addr(14'h1234, 1'b0);
    write_pulse(8'hA5);
    @(negedge pxclk);
    n_cmp++; if (ram_we !== 1'b1) begin n_err++; $display("FAIL write_we got %b exp 1", ram_we); end
    n_cmp++; if (ram_addr !== 14'h1234) begin n_err++; $display("FAIL write_addr got %h exp 1234", ram_addr); end
    n_cmp++; if (ram_wdata !== 8'hA5) begin n_err++; $display("FAIL write_data got %h exp a5", ram_wdata); end
    n_cmp++; if (cpu_wait !== EXP_WAIT_BUSY) begin n_err++; $display("FAIL write_wait got %b exp %b", cpu_wait, EXP_WAIT_BUSY); end
    model_mem[14'h1234] = 8'hA5;
    cyc();
    @(negedge pxclk);
    n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL write_idle_we got %b exp 0", ram_we); end
    n_cmp++; if (ram_addr !== 14'h1235) begin n_err++; $display("FAIL write_ptr got %h exp 1235", ram_addr); end
    n_cmp++; if (ram_mem[14'h1234] !== 8'hA5) begin n_err++; $display("FAIL write_mem got %h exp a5", ram_mem[14'h1234]); end
  endtask

  task automatic test_prefetch();
    bit seen;
    do_reset();
    load_addr(14'h0100, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge pxclk);
      if (cpu_rdata === 8'h5A) begin
        seen = 1'b1;
        break;
      end
      cyc();
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL prefetch_data got %h exp 5a within 3 clocks", cpu_rdata); end
    n_cmp++; if (ram_addr !== 14'h0101) begin n_err++; $display("FAIL prefetch_ptr got %h exp 0101", ram_addr); end
  endtask

  task automatic test_stall();
    logic [AW-1:0] prev;
    do_reset();
    load_addr(14'h0200, 1'b0);
    write_pulse(8'h3E);
    prev = '0;
    for (int i = 0; i < 5; i++) begin
      dma_rd_tick = 1'b1;
      dma_addr = AW'($urandom_range(0, DEPTH - 1));
      @(negedge pxclk);
      n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL stall_we cycle %0d got %b exp 0", i, ram_we); end
      n_cmp++; if (ram_addr !== dma_addr) begin n_err++; $display("FAIL stall_addr cycle %0d got %h exp %h", i, ram_addr, dma_addr); end
      if (i > 0) begin
        n_cmp++; if (vram_dout !== model_mem[prev]) begin n_err++; $display("FAIL stall_vram cycle %0d got %h exp %h", i, vram_dout, model_mem[prev]); end
      end
      prev = dma_addr;
      cyc();
    end
    dma_rd_tick = 1'b0;
    @(negedge pxclk);
    n_cmp++; if (vram_dout !== model_mem[prev]) begin n_err++; $display("FAIL stall_vram_last got %h exp %h", vram_dout, model_mem[prev]); end
    n_cmp++; if (ram_we !== 1'b1 || ram_addr !== 14'h0200 || ram_wdata !== 8'h3E) begin
      n_err++; $display("FAIL stall_release got we=%b addr=%h data=%h exp 1/0200/3e", ram_we, ram_addr, ram_wdata);
    end
    model_mem[14'h0200] = 8'h3E;
    cyc();
  endtask

  task automatic test_wrap();
    do_reset();
    load_addr(14'h3FFF, 1'b0);
    write_pulse(8'hC7);
    @(negedge pxclk);
    n_cmp++; if (ram_we !== 1'b1 || ram_addr !== 14'h3FFF) begin n_err++; $display("FAIL wrap_write got we=%b addr=%h exp 1/3fff", ram_we, ram_addr); end
    model_mem[14'h3FFF] = 8'hC7;
    cyc();
    @(negedge pxclk);
    n_cmp++; if (ram_addr !== 14'h0000) begin n_err++; $display("FAIL wrap_ptr got %h exp 0000", ram_addr); end
  endtask

  task automatic test_overrun();
    do_reset();
    // simultaneous addr+wr in IDLE: address wins, write dropped
    cpu_addr_tick = 1'b1; cpu_addr_in = 14'h0AAA; cpu_addr_rd = 1'b0;
    cpu_wr_tick = 1'b1; cpu_wdata = 8'h77;
    cyc();
    clear_cpu();
    @(negedge pxclk);
    n_cmp++; if (ram_we !== 1'b0 || ram_addr !== 14'h0AAA) begin n_err++; $display("FAIL prio_drop got we=%b addr=%h exp 0/0aaa", ram_we, ram_addr); end
    n_cmp++; if (cpu_overrun !== 1'b1) begin n_err++; $display("FAIL prio_overrun got %b exp 1", cpu_overrun); end
    do_reset();
    @(negedge pxclk);
    n_cmp++; if (cpu_overrun !== 1'b0) begin n_err++; $display("FAIL overrun_clear1 got %b exp 0", cpu_overrun); end
    cyc();
    load_addr(14'h0BBB, 1'b0);
    write_pulse(8'h3C);
    dma_rd_tick = 1'b1; dma_addr = 14'h0010;
    cpu_wr_tick = 1'b1; cpu_wdata = 8'hC3;
    cyc();
    clear_cpu();
    @(negedge pxclk);
    n_cmp++; if (cpu_overrun !== 1'b1) begin n_err++; $display("FAIL overrun_set got %b exp 1", cpu_overrun); end
    n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL overrun_stall_we got %b exp 0", ram_we); end
    cyc();
    dma_rd_tick = 1'b0;
    @(negedge pxclk);
    n_cmp++; if (ram_we !== 1'b1 || ram_addr !== 14'h0BBB || ram_wdata !== 8'h3C) begin
      n_err++; $display("FAIL overrun_first_write got we=%b addr=%h data=%h exp 1/0bbb/3c", ram_we, ram_addr, ram_wdata);
    end
    model_mem[14'h0BBB] = 8'h3C;
    cyc();
    for (int i = 0; i < 3; i++) begin
      @(negedge pxclk);
      n_cmp++; if (cpu_overrun !== 1'b1 || ram_we !== 1'b0) begin
        n_err++; $display("FAIL overrun_sticky cycle %0d got ovr=%b we=%b exp 1/0", i, cpu_overrun, ram_we);
      end
      cyc();
    end
    do_reset();
    @(negedge pxclk);
    n_cmp++; if (cpu_overrun !== 1'b0) begin n_err++; $display("FAIL overrun_clear2 got %b exp 0", cpu_overrun); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    load_addr(14'h0CCC, 1'b0);
    write_pulse(8'h99);
    reset = 1'b1;
    @(negedge pxclk);
    n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL rstmid_we_in_reset got %b exp 0", ram_we); end
    cyc();
    reset = 1'b0;
    @(negedge pxclk);
    n_cmp++; if (ram_we !== 1'b0 || cpu_wait !== 1'b0 || cpu_overrun !== 1'b0 || cpu_rdata !== 8'h00 || ram_addr !== 14'h0000) begin
      n_err++; $display("FAIL rstmid_outputs got we=%b wait=%b ovr=%b rdata=%h addr=%h exp 0/0/0/00/0000",
                        ram_we, cpu_wait, cpu_overrun, cpu_rdata, ram_addr);
    end
    cyc();
    @(negedge pxclk);
    n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL rstmid_abandon got %b exp 0", ram_we); end
    n_cmp++; if (ram_mem[14'h0CCC] !== model_mem[14'h0CCC]) begin n_err++; $display("FAIL rstmid_mem got %h exp %h", ram_mem[14'h0CCC], model_mem[14'h0CCC]); end
  endtask

  task automatic test_random();
    logic [AW-1:0] m_ptr;
    logic [7:0]    m_rdata;
    logic [AW-1:0] prev;
    logic          prev_dma;
    int            op, k;
    logic [AW-1:0] a;
    logic          rd;
    logic [7:0]    d;
    do_reset();
    m_ptr = '0; m_rdata = 8'h00; prev = '0; prev_dma = 1'b0;
    for (int t = 0; t < 60; t++) begin
      op = $urandom_range(0, 2);
      k  = $urandom_range(0, 4);
      a  = AW'($urandom_range(0, DEPTH - 1));
      rd = 1'($urandom_range(0, 1));
      d  = 8'($urandom_range(0, 255));
      for (int j = 0; j <= k + 3; j++) begin
        clear_cpu();
        if (j == 0) begin
          if (op == 0) begin cpu_addr_tick = 1'b1; cpu_addr_in = a; cpu_addr_rd = rd; end
          else if (op == 1) begin cpu_wr_tick = 1'b1; cpu_wdata = d; end
          else cpu_rd_tick = 1'b1;
        end
        dma_rd_tick = (j >= 1 && j <= k) ? 1'b1 : 1'($urandom_range(0, 1) & (j == 0 ? 1 : 0));
        dma_addr = AW'($urandom_range(0, DEPTH - 1));
        @(negedge pxclk);
        if (dma_rd_tick) begin
          n_cmp++; if (ram_we !== 1'b0 || ram_addr !== dma_addr) begin
            n_err++; $display("FAIL rand_dma_prio op %0d got we=%b addr=%h exp 0/%h", t, ram_we, ram_addr, dma_addr);
          end
        end
        if (prev_dma) begin
          n_cmp++; if (vram_dout !== model_mem[prev]) begin n_err++; $display("FAIL rand_vram op %0d got %h exp %h", t, vram_dout, model_mem[prev]); end
        end
        prev_dma = dma_rd_tick;
        prev = dma_addr;
        cyc();
      end
      clear_cpu();
      dma_rd_tick = 1'b0;
      case (op)
        0: begin m_ptr = a; if (rd) begin m_rdata = model_mem[a]; m_ptr = m_ptr + 1'b1; end end
        1: begin model_mem[m_ptr] = d; m_ptr = m_ptr + 1'b1; end
        default: begin m_rdata = model_mem[m_ptr]; m_ptr = m_ptr + 1'b1; end
      endcase
      @(negedge pxclk);
      n_cmp++; if (cpu_rdata !== m_rdata || ram_addr !== m_ptr || cpu_overrun !== 1'b0) begin
        n_err++; $display("FAIL rand_state op %0d kind %0d got rdata=%h ptr=%h ovr=%b exp %h/%h/0", t, op, cpu_rdata, ram_addr, cpu_overrun, m_rdata, m_ptr);
      end
      prev_dma = 1'b0;
      cyc();
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram_mem[i]   = 8'($urandom_range(0, 255));
      model_mem[i] = ram_mem[i];
    end
    ram_mem[14'h0100]   = 8'h5A;
    model_mem[14'h0100] = 8'h5A;
    test_reset();
    test_write();
    test_prefetch();
    test_stall();
    test_wrap();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
